// File: rtl/dbus_sram_responder.sv
// Single-port 64-bit SRAM responder for a valid/addr_ok/data_ok data bus.
// Define DBUS_RANDOM_DELAY_EN to add an LFSR-driven extra delay of 0..3 cycles per request.
module dbus_sram_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dreq_valid_i,
    input  logic [63:0] dreq_addr_i,
    input  logic [2:0]  dreq_size_i,
    input  logic [7:0]  dreq_strobe_i,
    input  logic [63:0] dreq_data_i,
    output logic        dresp_addr_ok_o,
    output logic        dresp_data_ok_o,
    output logic [63:0] dresp_data_o
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned MaxLat = LATENCY + 3;
    localparam int unsigned CW     = $clog2(MaxLat + 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] idx_q;
    logic [7:0]    strb_q;
    logic [63:0]   wdata_q;
    logic          data_ok_q;
    logic [63:0]   mem_q [DEPTH];

    logic [CW-1:0] lat_m1;
    logic          accept;

    // Size and sub-word/out-of-range address bits never influence storage.
    logic unused_dreq;
    assign unused_dreq = ^{dreq_addr_i[63:AW+3], dreq_addr_i[2:0], dreq_size_i};

    assign accept = (state_q == StIdle) && dreq_valid_i;

`ifdef DBUS_RANDOM_DELAY_EN
    logic [3:0] lfsr_q;
    // Delay uses the LFSR value held before this request advances it.
    assign lat_m1 = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 4'b1001;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end
`else
    assign lat_m1 = CW'(LATENCY - 1);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            data_ok_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        idx_q   <= dreq_addr_i[AW+2:3];
                        strb_q  <= dreq_strobe_i;
                        wdata_q <= dreq_data_i;
                        cnt_q   <= lat_m1;
                        if (lat_m1 == '0) begin
                            state_q   <= StResp;
                            data_ok_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q   <= StResp;
                        data_ok_q <= 1'b1;
                    end
                end
                StResp: begin
                    state_q   <= StIdle;
                    data_ok_q <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    data_ok_q <= 1'b0;
                end
            endcase
        end
    end

    // Write commits on the edge leaving RESP, so the response carries pre-write data.
    always_ff @(posedge clk) begin
        if (state_q == StResp) begin
            for (int i = 0; i < 8; i++) begin
                if (strb_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign dresp_addr_ok_o = accept;
    assign dresp_data_ok_o = data_ok_q;
    assign dresp_data_o    = data_ok_q ? mem_q[idx_q] : 64'h0;

endmodule
